// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte FIFO that feeds a uart_tx one byte at a time.
// Producers push at full clock rate; a three-state sequencer pops one byte,
// pulses o_tx_byte_rdy for a single cycle and waits for the transmitter's done
// pulse before it considers the next byte. Reset is synchronous, active-low.
module uart_tx_fifo #(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [7:0]        i_wr_byte,
   output logic              o_full,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow,
   output logic              o_tx_byte_rdy,
   output logic [7:0]        o_tx_byte,
   input  logic              i_tx_busy,
   input  logic              i_tx_done
);

   // Count is one bit wider than the pointers so DEPTH and 0 are distinct.
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for data and an idle transmitter
      ST_SEND = 2'd1,   // start pulse is on the wire this cycle
      ST_WAIT = 2'd2    // byte outstanding, waiting for i_tx_done
   } state_t;

   state_t            state_q;
   state_t            state_nxt;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_nxt;
   logic              full_q;
   logic              empty_q;
   logic              overflow_q;
   logic              tx_byte_rdy_q;
   logic [7:0]        tx_byte_q;

   logic              wr_accept;
   logic              wr_reject;
   logic              pop;

   // Write acceptance is judged on the registered full flag only, so a write
   // that coincides with a pop from a full FIFO is still dropped.
   always_comb begin
      wr_accept = i_wr_en && !full_q;
      wr_reject = i_wr_en &&  full_q;
   end

   // Sequencer next-state logic; pop is the single-cycle dequeue strobe.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      state_nxt = state_q;
      pop       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty_q && !i_tx_busy) begin
               pop       = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            // A very early done pulse is honoured here rather than lost.
            state_nxt = i_tx_done ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Occupancy after this edge: a simultaneous push and pop cancel out.
   always_comb begin
      count_nxt = count_q;
      unique case ({wr_accept, pop})
         2'b10:   count_nxt = count_q + CNT_ONE;
         2'b01:   count_nxt = count_q - CNT_ONE;
         default: count_nxt = count_q;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge i_clk) begin
      // NOTE: registered state always uses non-blocking assignment so every flop samples pre-edge values regardless of block order.
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Byte storage; writes are suppressed while reset is asserted.
   always_ff @(posedge i_clk) begin
      // NOTE: the storage array has no reset; stale entries are unreachable because count and pointers are reset.
      if (i_rst_n && wr_accept) begin
         mem[wr_ptr_q] <= i_wr_byte;
      end
   end

   // Pointers, occupancy and the registered flags derived from it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (wr_reject) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_nxt;
         full_q  <= (count_nxt == CNT_FULL);
         empty_q <= (count_nxt == '0);
      end
   end

   // Transmit handshake: latch the popped byte and raise the start pulse once.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tx_byte_rdy_q <= 1'b0;
         tx_byte_q     <= 8'h00;
      end else begin
         tx_byte_rdy_q <= pop;
         if (pop) begin
            tx_byte_q <= mem[rd_ptr_q];
         end
      end
   end

   assign o_full        = full_q;
   assign o_empty       = empty_q;
   assign o_count       = count_q;
   assign o_overflow    = overflow_q;
   assign o_tx_byte_rdy = tx_byte_rdy_q;
   assign o_tx_byte     = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DEPTH=4) with a behavioural uart_tx stand-in.
// A queue-based reference model tracks accepted bytes and occupancy; a
// negedge monitor scores every start pulse against it and checks the flags.
module tb_uart_tx_fifo;

   localparam int DEPTH        = 4;
   localparam int CLKS_PER_BIT = 4;
   localparam int FRAME        = 10 * CLKS_PER_BIT;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       wr_en     = 1'b0;
   logic [7:0] wr_byte   = 8'h00;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic       tx_byte_rdy;
   logic [7:0] tx_byte;
   logic       uart_busy = 1'b0;
   logic       uart_done = 1'b0;
   logic       spur_done = 1'b0;
   logic       hold_busy = 1'b0;
   logic       tx_done;
   int         uart_cnt  = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   logic [7:0] tx_log[$];
   int         pushed        = 0;
   int         popped        = 0;
   bit         exp_ovf       = 1'b0;
   bit         busy_at_edge  = 1'b0;
   bit         outstanding   = 1'b0;
   bit         mon_on        = 1'b0;
   int         last_done_cyc = -100;

   assign tx_done = uart_done | spur_done;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wr_en       (wr_en),
      .i_wr_byte     (wr_byte),
      .o_full        (full),
      .o_empty       (empty),
      .o_count       (count),
      .o_overflow    (overflow),
      .o_tx_byte_rdy (tx_byte_rdy),
      .o_tx_byte     (tx_byte),
      .i_tx_busy     (uart_busy),
      .i_tx_done     (tx_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx stand-in: busy for one frame after a start pulse, then a done pulse.
   always @(posedge clk) begin
      uart_done <= 1'b0;
      if (uart_cnt != 0) begin
         uart_cnt <= uart_cnt - 1;
         if (uart_cnt == 1) begin
            uart_done <= 1'b1;
            uart_busy <= hold_busy;
         end
      end else if (tx_byte_rdy === 1'b1) begin
         uart_busy <= 1'b1;
         uart_cnt  <= FRAME;
      end else begin
         uart_busy <= hold_busy;
      end
   end

   // Model: accept writes while occupancy (before this edge) is below DEPTH.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         pushed  = 0;
         popped  = 0;
         exp_ovf = 1'b0;
      end else if (wr_en) begin
         if (pushed - popped < DEPTH) begin
            exp_q.push_back(wr_byte);
            pushed++;
         end else begin
            exp_ovf = 1'b1;
         end
      end
      busy_at_edge = uart_busy;
   end

   // Monitor: score every start pulse and compare flags with the model.
   always @(negedge clk) begin
      int         exp_cnt;
      logic [7:0] exp_b;
      if (mon_on) begin
         if (tx_byte_rdy === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rdy_unexpected: o_tx_byte_rdy=1 (byte %02h) with model queue empty, required 0", tx_byte);
            end else begin
               exp_b = exp_q.pop_front();
               popped++;
               if (tx_byte !== exp_b) begin
                  n_fail++;
                  $display("FAIL tx_order: o_tx_byte=%02h, required %02h", tx_byte, exp_b);
               end
            end
            n_checks++;
            if (outstanding || busy_at_edge) begin
               n_fail++;
               $display("FAIL rdy_while_busy: pulse issued with outstanding=%0b busy=%0b, required both 0", outstanding, busy_at_edge);
            end
            outstanding = 1'b1;
            tx_log.push_back(tx_byte);
         end
         if (tx_done === 1'b1) begin
            outstanding   = 1'b0;
            last_done_cyc = cyc;
         end
         exp_cnt = pushed - popped;
         n_checks++;
         if (count !== 3'(exp_cnt) || empty !== (exp_cnt == 0) ||
             full !== (exp_cnt == DEPTH) || overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL flags: count=%0d empty=%0b full=%0b ovf=%0b, required count=%0d empty=%0b full=%0b ovf=%0b",
                     count, empty, full, overflow, exp_cnt, exp_cnt == 0, exp_cnt == DEPTH, exp_ovf);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_burst(input logic [7:0] b[$]);
      foreach (b[i]) begin
         wr_en   = 1'b1;
         wr_byte = b[i];
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic wait_rdy(input string tag, output int c);
      c = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_byte_rdy === 1'b1) begin
            c = cyc;
            break;
         end
      end
      n_checks++;
      if (c < 0) begin
         n_fail++;
         $display("FAIL %s_timeout: o_tx_byte_rdy stayed 0 for 200 cycles, required a pulse", tag);
      end
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (empty === 1'b1 && !uart_busy && uart_cnt == 0 && !outstanding && tx_byte_rdy === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      tick(2);
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_drain: FIFO did not drain within 2000 cycles, required empty and idle", tag);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      wr_en   = 1'b1;
      wr_byte = 8'hFF;
      tick(2);
      n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL reset_count: %0d, required 0", count); end
      n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty: %0b, required 1", empty); end
      n_checks++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full: %0b, required 0", full); end
      n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: %0b, required 0", overflow); end
      n_checks++; if (tx_byte_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: %0b, required 0", tx_byte_rdy); end
      n_checks++; if (tx_byte !== 8'h00)   begin n_fail++; $display("FAIL reset_txbyte: %02h, required 00", tx_byte); end
      wr_en  = 1'b0;
      rst_n  = 1'b1;
      mon_on = 1'b1;
      tick(2);
   endtask

   task automatic test_single_byte();
      int wcyc, c;
      tx_log.delete();
      wr_en   = 1'b1;
      wr_byte = 8'hA5;
      @(negedge clk);
      wr_en = 1'b0;
      wcyc  = cyc;
      wait_rdy("single", c);
      n_checks++; if (c != wcyc + 1)      begin n_fail++; $display("FAIL single_latency: pulse at cycle %0d, required %0d", c, wcyc + 1); end
      n_checks++; if (tx_byte !== 8'hA5)  begin n_fail++; $display("FAIL single_byte: %02h, required A5", tx_byte); end
      @(negedge clk);
      n_checks++; if (tx_byte_rdy !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: rdy=%0b one cycle later, required 0", tx_byte_rdy); end
      wait_idle("single");
      n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL single_empty_after: %0b, required 1", empty); end
   endtask

   task automatic test_burst();
      logic [7:0] b[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
      int c;
      tx_log.delete();
      write_burst(b);
      // Four writes on consecutive edges; the first byte was popped one edge after it landed.
      n_checks++; if (count !== 3'(4 - 1)) begin n_fail++; $display("FAIL burst_peak_count: %0d, required 3", count); end
      for (int k = 1; k < 4; k++) begin
         wait_rdy("burst", c);
         n_checks++; if (tx_byte !== b[k]) begin n_fail++; $display("FAIL burst_byte: %02h, required %02h", tx_byte, b[k]); end
         n_checks++; if (c - last_done_cyc != 2) begin n_fail++; $display("FAIL burst_gap: pulse %0d cycles after done, required 2", c - last_done_cyc); end
      end
      wait_idle("burst");
      n_checks++;
      if (tx_log.size() != 4 || tx_log[0] !== 8'h01 || tx_log[3] !== 8'h04) begin
         n_fail++; $display("FAIL burst_log: %0d bytes sent, required 01..04 in order", tx_log.size());
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b[$] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      tx_log.delete();
      hold_busy = 1'b1;
      tick(2);
      write_burst(b);
      n_checks++; if (count !== 3'd4)    begin n_fail++; $display("FAIL ovf_count: %0d, required 4", count); end
      n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full: %0b, required 1", full); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: %0b, required 1", overflow); end
      hold_busy = 1'b0;
      wait_idle("ovf");
      n_checks++;
      if (tx_log.size() != 4) begin
         n_fail++; $display("FAIL ovf_log_len: %0d bytes sent, required 4", tx_log.size());
      end else begin
         foreach (tx_log[i]) if (tx_log[i] !== b[i]) begin
            n_fail++; $display("FAIL ovf_log: byte %0d = %02h, required %02h", i, tx_log[i], b[i]);
         end
      end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: %0b, required 1", overflow); end
   endtask

   task automatic test_wrap();
      logic [7:0] sent[$];
      logic [7:0] b[$];
      tx_log.delete();
      for (int r = 0; r < 3; r++) begin
         b.delete();
         for (int i = 0; i < 3; i++) b.push_back(8'($urandom));
         write_burst(b);
         foreach (b[i]) sent.push_back(b[i]);
         wait_idle("wrap");
      end
      n_checks++;
      if (tx_log.size() != sent.size()) begin
         n_fail++; $display("FAIL wrap_log_len: %0d, required %0d", tx_log.size(), sent.size());
      end else begin
         foreach (sent[i]) if (tx_log[i] !== sent[i]) begin
            n_fail++; $display("FAIL wrap_order: byte %0d = %02h, required %02h", i, tx_log[i], sent[i]);
         end
      end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_count: %0d, required 0", count); end
   endtask

   task automatic test_simul_push_pop();
      logic [7:0] b[$];
      logic [7:0] c3;
      b.push_back(8'($urandom));
      b.push_back(8'($urandom));
      c3 = 8'($urandom);
      tx_log.delete();
      hold_busy = 1'b1;
      tick(2);
      write_burst(b);
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_pre_count: %0d, required 2", count); end
      hold_busy = 1'b0;
      @(negedge clk);                 // transmitter goes idle on this edge
      wr_en   = 1'b1;
      wr_byte = c3;
      @(negedge clk);                 // pop and push share this edge
      wr_en = 1'b0;
      n_checks++; if (count !== 3'd2)       begin n_fail++; $display("FAIL simul_count: %0d, required 2", count); end
      n_checks++; if (tx_byte_rdy !== 1'b1) begin n_fail++; $display("FAIL simul_rdy: %0b, required 1", tx_byte_rdy); end
      n_checks++; if (tx_byte !== b[0])     begin n_fail++; $display("FAIL simul_byte: %02h, required %02h", tx_byte, b[0]); end
      wait_idle("simul");
      n_checks++;
      if (tx_log.size() != 3 || tx_log[0] !== b[0] || tx_log[1] !== b[1] || tx_log[2] !== c3) begin
         n_fail++; $display("FAIL simul_order: %0d bytes sent, required %02h %02h %02h", tx_log.size(), b[0], b[1], c3);
      end
   endtask

   task automatic test_spurious_done();
      int wcyc, c;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      n_checks++; if (tx_byte_rdy !== 1'b0) begin n_fail++; $display("FAIL spur_rdy: %0b, required 0", tx_byte_rdy); end
      wr_en   = 1'b1;
      wr_byte = 8'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      wcyc  = cyc;
      wait_rdy("spur", c);
      n_checks++; if (c != wcyc + 1) begin n_fail++; $display("FAIL spur_latency: pulse at cycle %0d, required %0d", c, wcyc + 1); end
      wait_idle("spur");
   endtask

   task automatic test_reset_mid_stream();
      logic [7:0] b[$];
      int c;
      for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
      write_burst(b);
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre_count: %0d, required 3", count); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL rstmid_count: %0d, required 0", count); end
      n_checks++; if (empty !== 1'b1)       begin n_fail++; $display("FAIL rstmid_empty: %0b, required 1", empty); end
      n_checks++; if (tx_byte_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: %0b, required 0", tx_byte_rdy); end
      for (int i = 0; i < FRAME + 8 && (uart_busy || i < 4); i++) begin
         @(negedge clk);
         n_checks++;
         if (tx_byte_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: rdy=%0b after reset, required 0", tx_byte_rdy); end
      end
      wr_en   = 1'b1;
      wr_byte = 8'h5A;
      @(negedge clk);
      wr_en = 1'b0;
      wait_rdy("rstmid", c);
      n_checks++; if (tx_byte !== 8'h5A) begin n_fail++; $display("FAIL rstmid_fresh: %02h, required 5A", tx_byte); end
      wait_idle("rstmid");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr_en     = ($urandom_range(0, 99) < 40);
         wr_byte   = 8'($urandom);
         hold_busy = ($urandom_range(0, 99) < 10);
         @(negedge clk);
      end
      wr_en     = 1'b0;
      hold_busy = 1'b0;
      wait_idle("random");
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_leftover: %0d bytes never sent, required 0", exp_q.size()); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_burst();
      test_overflow();
      test_wrap();
      test_simul_push_pop();
      test_spurious_done();
      test_reset_mid_stream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
